l1i_line_fetcher: RTL
=====================

// Module: l1i_line_fetcher
// PURPOSE
// - Bus initiator for the instruction SDRAM word bus (addr/start -> q/done/ready).
// - Sits between the L1 I-cache miss logic and the SDRAM controller.
// - On a line-fill request it issues LINE_WORDS sequential single-word reads.
// - Each returned word is streamed into the cache data array, then line completion is signalled.
// PARAMETERS
// - LINE_WORDS  4    words per cache line; power of 2, range 2..16
// - IDX_W       2    log2(LINE_WORDS); width of wr_idx
// - TIMEOUT     255  max cycles waiting for bus_i_sdram_done (TIMEOUT_EN only); 1..255
// PORTS
// - clk                clock: in   1   single system clock, all logic on posedge
// - reset              reset: in   1   asynchronous, active-low (0 = reset)
// - req                in   1      line-fill request; sampled only in IDLE
// - req_addr           in   27     word address of miss; low IDX_W bits ignored (forced 0)
// - busy               out  1      high from request acceptance until line_done/err
// - line_done          out  1      one-cycle pulse after the last word is written
// - err                out  1      one-cycle pulse on timeout abort; constant 0 without TIMEOUT_EN
// - wr_en              out  1      one-cycle pulse per captured word
// - wr_idx             out  IDX_W  word index within line for wr_data
// - wr_data            out  32     captured bus_i_sdram_q
// - bus_i_sdram_addr   out  27     word address of current read
// - bus_i_sdram_start  out  1      one-cycle request pulse per word
// - bus_i_sdram_q      in   32     read data; valid when done=1
// - bus_i_sdram_done   in   1      read complete, one-cycle pulse from responder
// - bus_i_sdram_ready  in   1      responder idle and able to accept start
// BEHAVIOUR
// - Reset values:
//   - all outputs registered, 0 during reset (addr=0, wr_idx=0, wr_data=0)
//   - state=IDLE, word counter=0
// - States:
//   - IDLE -> ISSUE when req=1 (base <= {req_addr[26:IDX_W], IDX_W'b0}, cnt<=0, busy<=1).
//   - ISSUE: if ready=1, start<=1 for exactly one cycle, addr<=base+cnt, -> WAIT.
//     If ready=0, hold in ISSUE with start=0.
//   - WAIT: start=0. On done=1: wr_data<=q, wr_idx<=cnt, wr_en<=1.
//     - If cnt==LINE_WORDS-1: line_done<=1, busy<=0, -> IDLE.
//     - Else cnt<=cnt+1, -> ISSUE.
// - start is never asserted in two consecutive cycles.
//   start is never asserted while a read is outstanding.
// - Latency, zero-wait responder (done one cycle after start, ready held 1):
//   - 2 cycles per word.
//   - line_done high 2*LINE_WORDS cycles after the req-sampling edge (8 for default).
// - busy drops in the same cycle line_done/err pulses.
//   A new req may be sampled on the following edge.
// - Boundary conditions:
//   - req while busy: ignored (not queued).
//   - done outside WAIT: ignored.
//   - Address adds never carry out of the aligned line, so no 27-bit wrap.
//   - reset asserted mid-line: immediate return to IDLE, start/wr_en drop.
//     A late done from the responder after release is ignored.
//   - ready may drop between words; the fetcher re-waits in ISSUE with no data loss.
// CONFIGURATION
// - TIMEOUT_EN defined:
//   - 8-bit watchdog clears on entering WAIT and counts each WAIT cycle without done.
//   - On reaching TIMEOUT: err<=1 (one cycle), busy<=0, -> IDLE; no line_done, no further wr_en.
// - TIMEOUT_EN undefined:
//   - No watchdog; WAIT holds indefinitely; err tied 0.
// TESTING
// - Zero-wait responder, req_addr=0x000_0013:
//   - Reads issued at 0x10,0x11,0x12,0x13.
//   - wr_idx 0..3 carry mem[0x10..0x13].
//   - line_done 8 cycles after the req edge.
// - Responder latency 3 (done 4 cycles after start):
//   - Exactly 4 start pulses, 2+ idle cycles between each.
//   - line_done after 4*5=20 cycles; busy high throughout.
// - ready=0 for 5 cycles after the 2nd word:
//   - No start while ready=0.
//   - Third start on the first cycle ready=1 is seen; data still correct.
// - req pulsed again at cycle 3 of a fill with req_addr=0x40:
//   - Ignored; only addresses 0x10..0x13 appear on the bus.
// - reset low for 1 cycle while in WAIT of word 2:
//   - All outputs 0, state IDLE, no line_done.
//   - Subsequent req=0x20 fills cleanly.
// - TIMEOUT_EN, TIMEOUT=10, responder never asserts done:
//   - err pulses 10 cycles after the first start, busy=0, no wr_en.
//   - Without TIMEOUT_EN, busy stays 1.

Source files
------------

// File: rtl/l1i_line_fetcher.sv
// L1 I-cache line fetcher: issues LINE_WORDS single-word SDRAM reads per miss and streams them to the data array.
// Optional TIMEOUT_EN macro adds a WAIT watchdog that aborts the line with an err pulse.
module l1i_line_fetcher #(
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [26:0]      req_addr,
   output logic             busy,
   output logic             line_done,
   output logic             err,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [31:0]      wr_data,
   output logic [26:0]      bus_i_sdram_addr,
   output logic             bus_i_sdram_start,
   input  logic [31:0]      bus_i_sdram_q,
   input  logic             bus_i_sdram_done,
   input  logic             bus_i_sdram_ready
);

   localparam int unsigned ADDR_W = 27;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   if (LINE_WORDS != (1 << IDX_W) || LINE_WORDS < 2 || LINE_WORDS > 16 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("l1i_line_fetcher: illegal LINE_WORDS/IDX_W/TIMEOUT combination");
   end

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic                issue_c;
   logic                busy_d, line_done_d, err_d, wr_en_d, start_d;
   logic [IDX_W-1:0]    wr_idx_d;
   logic [DATA_W-1:0]   wr_data_d;
   logic [ADDR_W-1:0]   addr_d;
`ifdef TIMEOUT_EN
   logic [7:0]          wdog_q, wdog_d;
`endif

   // Next-state and next-output logic; a start is launched on the same edge the
   // word slot opens when ready is already high, otherwise ISSUE holds until it is.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      busy_d      = busy;
      line_done_d = 1'b0;
      err_d       = 1'b0;
      wr_en_d     = 1'b0;
      start_d     = 1'b0;
      wr_idx_d    = wr_idx;
      wr_data_d   = wr_data;
      addr_d      = bus_i_sdram_addr;
      issue_c     = 1'b0;
`ifdef TIMEOUT_EN
      wdog_d      = wdog_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               base_d  = req_addr & ~ADDR_W'(LINE_WORDS - 1);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ISSUE;
               issue_c = 1'b1;
            end
         end
         ISSUE: begin
            issue_c = 1'b1;
         end
         WAIT: begin
            // done coinciding with our own start cycle cannot belong to this read
            if (bus_i_sdram_done && !bus_i_sdram_start) begin
               wr_en_d   = 1'b1;
               wr_idx_d  = cnt_q;
               wr_data_d = bus_i_sdram_q;
               if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
                  line_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = IDLE;
               end else begin
                  cnt_d   = IDX_W'(cnt_q + 1'b1);
                  state_d = ISSUE;
                  issue_c = 1'b1;
               end
            end
`ifdef TIMEOUT_EN
            else if (wdog_q == 8'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               wdog_d = 8'(wdog_q + 1'b1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      if (issue_c && bus_i_sdram_ready) begin
         start_d = 1'b1;
         addr_d  = base_d + ADDR_W'(cnt_d);
         state_d = WAIT;
`ifdef TIMEOUT_EN
         wdog_d  = '0;
`endif
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         base_q            <= '0;
         cnt_q             <= '0;
         busy              <= 1'b0;
         line_done         <= 1'b0;
         err               <= 1'b0;
         wr_en             <= 1'b0;
         wr_idx            <= '0;
         wr_data           <= '0;
         bus_i_sdram_addr  <= '0;
         bus_i_sdram_start <= 1'b0;
`ifdef TIMEOUT_EN
         wdog_q            <= '0;
`endif
      end else begin
         state_q           <= state_d;
         base_q            <= base_d;
         cnt_q             <= cnt_d;
         busy              <= busy_d;
         line_done         <= line_done_d;
         err               <= err_d;
         wr_en             <= wr_en_d;
         wr_idx            <= wr_idx_d;
         wr_data           <= wr_data_d;
         bus_i_sdram_addr  <= addr_d;
         bus_i_sdram_start <= start_d;
`ifdef TIMEOUT_EN
         wdog_q            <= wdog_d;
`endif
      end
   end

endmodule
